// File: rtl/ledcount_sched_if.sv
// Requester and response handshake bundle for ledcount_sched.
// The slave modport is the scheduler's view; the master modport is the client's view.
interface ledcount_sched_if #(
   parameter int N_REQ = 4,
   parameter int A_W   = 6,
   parameter int B_W   = 4
);
   localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [N_REQ-1:0]     req_valid;
   logic [N_REQ*A_W-1:0] req_data;
   logic [N_REQ-1:0]     req_ready;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [ID_W-1:0]      rsp_id;
   logic [B_W-1:0]       rsp_data;
   logic [A_W-1:0]       rsp_operand;

   modport master (
      output req_valid, req_data, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_operand
   );

   modport slave (
      input  req_valid, req_data, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_data, rsp_operand
   );
endinterface

// File: rtl/ledcount_sched.sv
// Round-robin scheduler sharing one combinational ledcount datapath among N_REQ requesters.
// One transaction in flight: grant in IDLE, hold lc_a for SETTLE cycles, return the sampled result.
module ledcount_sched #(
   parameter int N_REQ  = 4,
   parameter int A_W    = 6,
   parameter int B_W    = 4,
   parameter int SETTLE = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   ledcount_sched_if.slave       bus,
   output logic [A_W-1:0]        lc_a,
   input  logic [B_W-1:0]        lc_b,
   output logic                  busy
);
   localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int IDX_W = ID_W + 1;
   localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [A_W-1:0]    lc_a_q, lc_a_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [B_W-1:0]    rsp_data_q, rsp_data_d;
   logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
   logic [A_W-1:0]    rsp_operand_q, rsp_operand_d;
   logic              busy_q, busy_d;

   logic              found_s;
   logic [ID_W-1:0]   winner_s;
   logic [IDX_W-1:0]  idx_s;
   logic [A_W-1:0]    sel_data_s;
   logic [N_REQ-1:0]  req_ready_s;

   // Rotating priority scan from rr_ptr; the index folds back below N_REQ so odd sizes work.
   always_comb begin
      found_s  = 1'b0;
      winner_s = '0;
      idx_s    = '0;
      for (int k = 0; k < N_REQ; k++) begin
         idx_s = {1'b0, rr_ptr_q} + IDX_W'(k);
         if (idx_s >= IDX_W'(N_REQ)) begin
            idx_s = idx_s - IDX_W'(N_REQ);
         end else begin
            idx_s = idx_s;
         end
         if (!found_s && bus.req_valid[idx_s[ID_W-1:0]]) begin
            found_s  = 1'b1;
            winner_s = idx_s[ID_W-1:0];
         end else begin
            found_s  = found_s;
         end
      end
   end

   assign sel_data_s = bus.req_data[int'(winner_s)*A_W +: A_W];

   // Grant is combinational and only offered while idle and out of reset.
   always_comb begin
      req_ready_s = '0;
      if (rst_n && (state_q == ST_IDLE) && found_s) begin
         req_ready_s[winner_s] = 1'b1;
      end else begin
         req_ready_s = '0;
      end
   end

   // Next-state and datapath register updates.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      rr_ptr_d      = rr_ptr_q;
      lc_a_d        = lc_a_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_data_d    = rsp_data_q;
      rsp_id_d      = rsp_id_q;
      rsp_operand_d = rsp_operand_q;
      case (state_q)
         ST_IDLE: begin
            if (found_s) begin
               state_d       = ST_SETTLE;
               lc_a_d        = sel_data_s;
               rsp_operand_d = sel_data_s;
               rsp_id_d      = winner_s;
               cnt_d         = CNT_W'(SETTLE - 1);
               if (winner_s == ID_W'(N_REQ - 1)) begin
                  rr_ptr_d = '0;
               end else begin
                  rr_ptr_d = winner_s + ID_W'(1);
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SETTLE: begin
            if (cnt_q == '0) begin
               rsp_data_d  = lc_b;
               rsp_valid_d = 1'b1;
               state_d     = ST_RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_RESP: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end else begin
               state_d = ST_RESP;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            rsp_valid_d = 1'b0;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers; async reset drops any in-flight transaction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         rr_ptr_q      <= '0;
         lc_a_q        <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_data_q    <= '0;
         rsp_id_q      <= '0;
         rsp_operand_q <= '0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         rr_ptr_q      <= rr_ptr_d;
         lc_a_q        <= lc_a_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_data_q    <= rsp_data_d;
         rsp_id_q      <= rsp_id_d;
         rsp_operand_q <= rsp_operand_d;
         busy_q        <= busy_d;
      end
   end

   assign bus.req_ready   = req_ready_s;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_data    = rsp_data_q;
   assign bus.rsp_id      = rsp_id_q;
   assign bus.rsp_operand = rsp_operand_q;
   assign lc_a            = lc_a_q;
   assign busy            = busy_q;
endmodule

// File: tb/tb_ledcount_sched.sv
// Randomized and directed bench for ledcount_sched: a transaction-level model predicts grants
// and timing, pushes expected responses into a scoreboard, and a monitor pops them on each handshake.
module tb_ledcount_sched;
   localparam int N  = 4;
   localparam int AW = 6;
   localparam int BW = 4;
   localparam int ST = 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [AW-1:0] lc_a;
   logic [BW-1:0] lc_b;
   logic          busy;

   always #5 clk = ~clk;

   ledcount_sched_if #(.N_REQ(N), .A_W(AW), .B_W(BW)) bus ();

   ledcount_sched #(.N_REQ(N), .A_W(AW), .B_W(BW), .SETTLE(ST)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave),
      .lc_a  (lc_a),
      .lc_b  (lc_b),
      .busy  (busy)
   );

   assign lc_b = lc_a[5:2];

   typedef struct { int id; int op; int data; } exp_t;
   exp_t sb[$];
   int   log_id[$];
   int   log_data[$];
   int   log_cyc[$];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Transaction-level reference: rotating priority, one outstanding job, fixed latency.
   int           m_ptr = 0;
   bit           m_out = 0;
   int           m_rise = 0;
   bit           m_fnd;
   int           m_win;
   int           m_op;
   logic [N-1:0] m_rdy;
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            m_ptr = 0;
            m_out = 0;
            sb.delete();
            chk("ready_in_reset", 32'(bus.req_ready), 32'd0);
            chk("valid_in_reset", 32'(bus.rsp_valid), 32'd0);
         end else begin
            m_fnd = 0;
            m_win = 0;
            m_rdy = '0;
            if (!m_out) begin
               for (int k = 0; k < N; k++) begin
                  if (!m_fnd && bus.req_valid[(m_ptr + k) % N]) begin
                     m_fnd = 1;
                     m_win = (m_ptr + k) % N;
                  end
               end
            end
            if (m_fnd) m_rdy[m_win] = 1'b1;
            chk("req_ready", 32'(bus.req_ready), 32'(m_rdy));
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_out && (cyc >= m_rise)));
            chk("busy", 32'(busy), 32'(m_out));
            if (m_out && (cyc >= m_rise) && bus.rsp_ready) begin
               m_out = 0;
            end else if (m_fnd) begin
               m_out  = 1;
               m_rise = cyc + 1 + ST;
               m_ptr  = (m_win + 1) % N;
               m_op   = int'(bus.req_data[m_win*AW +: AW]);
               sb.push_back('{m_win, m_op, m_op / 4});
            end
         end
      end
   end

   // Response monitor: checks hold-stability under backpressure and pops on each handshake.
   bit            held = 0;
   int            p_id, p_data, p_op;
   exp_t          e;
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && bus.rsp_valid) begin
            if (held) begin
               chk("hold_id", 32'(bus.rsp_id), 32'(p_id));
               chk("hold_data", 32'(bus.rsp_data), 32'(p_data));
               chk("hold_operand", 32'(bus.rsp_operand), 32'(p_op));
            end
            if (bus.rsp_ready) begin
               held = 0;
               if (sb.size() == 0) begin
                  chk("unexpected_rsp", 32'd1, 32'd0);
               end else begin
                  e = sb.pop_front();
                  chk("rsp_id", 32'(bus.rsp_id), 32'(e.id));
                  chk("rsp_operand", 32'(bus.rsp_operand), 32'(e.op));
                  chk("rsp_data", 32'(bus.rsp_data), 32'(e.data));
                  log_id.push_back(int'(bus.rsp_id));
                  log_data.push_back(int'(bus.rsp_data));
                  log_cyc.push_back(cyc);
               end
            end else begin
               held   = 1;
               p_id   = int'(bus.rsp_id);
               p_data = int'(bus.rsp_data);
               p_op   = int'(bus.rsp_operand);
            end
         end else begin
            held = 0;
         end
      end
   end

   logic [N-1:0]  pend;
   logic [AW-1:0] pdata [N];
   bit            rdy_drv;
   int            n_acc;

   task automatic cycle();
      @(posedge clk);
      #1;
      bus.req_valid = pend;
      for (int i = 0; i < N; i++) bus.req_data[i*AW +: AW] = pdata[i];
      bus.rsp_ready = rdy_drv;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         if (pend[i] && bus.req_ready[i]) begin
            pend[i] = 1'b0;
            n_acc++;
         end
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      rdy_drv = 1'b1;
      while ((sb.size() != 0 || pend != '0) && n < 80) begin
         cycle();
         n++;
      end
      chk("drain_timeout", 32'(sb.size() != 0 || pend != '0), 32'd0);
   endtask

   task automatic clear_logs();
      log_id.delete();
      log_data.delete();
      log_cyc.delete();
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #2;
      bus.req_valid = '0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      int n;
      int rr_ids  [5];
      int rr_vals [5];
      rr_ids  = '{0, 1, 2, 3, 0};
      rr_vals = '{1, 2, 3, 4, 1};
      pend = '0;
      rdy_drv = 1'b1;
      n_acc = 0;
      for (int i = 0; i < N; i++) pdata[i] = '0;
      bus.req_valid = '1;
      bus.req_data  = '1;
      bus.rsp_ready = 1'b0;

      // Reset values, with every requester valid to show the grant is suppressed.
      repeat (3) @(posedge clk);
      #2;
      chk("rst_lc_a", 32'(lc_a), 32'd0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
      chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
      chk("rst_rsp_operand", 32'(bus.rsp_operand), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
      bus.req_valid = '0;
      rst_n = 1'b1;

      // Single request: operand 44 -> 11.
      clear_logs();
      pend[0] = 1'b1;
      pdata[0] = 6'd44;
      cycle();
      chk("single_grant_now", 32'(pend[0]), 32'd0);
      wait_idle();
      chk("single_count", 32'(log_id.size()), 32'd1);
      if (log_id.size() > 0) begin
         chk("single_id", 32'(log_id[0]), 32'd0);
         chk("single_data", 32'(log_data[0]), 32'd11);
      end

      // Sweep 0,4,..,44 on requester 0 at full rate.
      clear_logs();
      for (int v = 0; v < 12; v++) begin
         pend[0] = 1'b1;
         pdata[0] = AW'(v * 4);
         n = 0;
         while (pend[0] && n < 20) begin
            cycle();
            n++;
         end
      end
      wait_idle();
      chk("sweep_count", 32'(log_data.size()), 32'd12);
      for (int v = 0; v < log_data.size() && v < 12; v++) begin
         chk("sweep_data", 32'(log_data[v]), 32'(v));
         if (v > 0) chk("sweep_gap", 32'(log_cyc[v] - log_cyc[v-1]), 32'd3);
      end

      // Round-robin with all four held valid from a fresh pointer.
      pulse_reset();
      clear_logs();
      pdata[0] = 6'd4; pdata[1] = 6'd8; pdata[2] = 6'd12; pdata[3] = 6'd16;
      n = 0;
      while (log_id.size() < 5 && n < 40) begin
         pend = '1;
         cycle();
         n++;
      end
      pend = '0;
      wait_idle();
      chk("rr_count", 32'(log_id.size()), 32'd5);
      for (int i = 0; i < log_id.size() && i < 5; i++) begin
         chk("rr_id", 32'(log_id[i]), 32'(rr_ids[i]));
         chk("rr_data", 32'(log_data[i]), 32'(rr_vals[i]));
      end

      // Backpressure: hold the response 5 cycles while another requester waits.
      clear_logs();
      rdy_drv = 1'b0;
      pend[1] = 1'b1;
      pdata[1] = 6'd40;
      n = 0;
      while (!bus.rsp_valid && n < 20) begin
         cycle();
         n++;
      end
      chk("bp_rsp_seen", 32'(bus.rsp_valid), 32'd1);
      pend[2] = 1'b1;
      pdata[2] = 6'd60;
      repeat (5) cycle();
      chk("bp_no_rsp_yet", 32'(log_id.size()), 32'd0);
      chk("bp_waiting", 32'(pend[2]), 32'd1);
      rdy_drv = 1'b1;
      cycle();
      chk("bp_rsp_taken", 32'(log_id.size()), 32'd1);
      cycle();
      chk("bp_next_accept", 32'(pend[2]), 32'd0);
      wait_idle();

      // Pointer wrap: grant 3, then 0 and 3 both valid -> 0 wins.
      clear_logs();
      pend = 4'b1000;
      pdata[3] = 6'd12;
      wait_idle();
      pend = 4'b1001;
      pdata[0] = 6'd8;
      pdata[3] = 6'd28;
      wait_idle();
      chk("wrap_count", 32'(log_id.size()), 32'd3);
      if (log_id.size() == 3) begin
         chk("wrap_first", 32'(log_id[0]), 32'd3);
         chk("wrap_winner", 32'(log_id[1]), 32'd0);
         chk("wrap_last", 32'(log_id[2]), 32'd3);
      end

      // Reset during SETTLE drops the job; pointer restarts at 0.
      clear_logs();
      pend = 4'b0001;
      pdata[0] = 6'd20;
      cycle();
      @(posedge clk);
      #2;
      chk("mid_busy", 32'(busy), 32'd1);
      bus.req_valid = '1;
      rst_n = 1'b0;
      #1;
      chk("mid_lc_a", 32'(lc_a), 32'd0);
      chk("mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("mid_rsp_operand", 32'(bus.rsp_operand), 32'd0);
      chk("mid_rsp_id", 32'(bus.rsp_id), 32'd0);
      chk("mid_rsp_data", 32'(bus.rsp_data), 32'd0);
      chk("mid_busy_clr", 32'(busy), 32'd0);
      chk("mid_req_ready", 32'(bus.req_ready), 32'd0);
      repeat (2) @(posedge clk);
      #2;
      bus.req_valid = '0;
      rst_n = 1'b1;
      pend = '1;
      pdata[0] = 6'd36; pdata[1] = 6'd4; pdata[2] = 6'd8; pdata[3] = 6'd12;
      wait_idle();
      chk("post_rst_count", 32'(log_id.size()), 32'd4);
      if (log_id.size() > 0) begin
         chk("post_rst_first", 32'(log_id[0]), 32'd0);
         chk("post_rst_data", 32'(log_data[0]), 32'd9);
      end

      // Random traffic with random backpressure.
      clear_logs();
      n_acc = 0;
      for (int r = 0; r < 400; r++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(3) == 0) begin
               pend[i]  = 1'b1;
               pdata[i] = AW'($urandom);
            end
         end
         rdy_drv = ($urandom_range(2) != 0);
         cycle();
      end
      wait_idle();
      repeat (3) cycle();
      chk("rand_count", 32'(log_id.size()), 32'(n_acc));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
